// File: rtl/coffee_brew_seq_pkg.sv
// Shared types and default phase lengths for the brewing sequencer.
// Also holds the helper that checks whether a phase length fits the counter.
package coffee_pkg;

    typedef enum logic [1:0] {
        DRINK_NONE = 2'b00,
        DRINK_ESPR = 2'b01,
        DRINK_LONG = 2'b10,
        DRINK_CAPP = 2'b11
    } drink_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRIND     = 3'd1,
        HEAT_WAIT = 3'd2,
        POUR      = 3'd3,
        MILK      = 3'd4,
        DONE      = 3'd5,
        FAULT     = 3'd6
    } state_t;

    localparam int DEF_CNT_W        = 8;
    localparam int DEF_GRIND_CYC    = 8;
    localparam int DEF_HEAT_TIMEOUT = 32;
    localparam int DEF_POUR_SHORT   = 10;
    localparam int DEF_POUR_LONG    = 20;
    localparam int DEF_MILK_CYC     = 12;

    // A phase of len cycles loads len-1, which must be representable in w bits.
    function automatic bit fitsWidth(input int len, input int w);
        return (len >= 1) && ((len - 1) < (1 << w));
    endfunction

endpackage

// File: rtl/coffee_brew_seq_phase_timer.sv
// Loadable down-counter used to time every brewing phase.
// The count saturates at zero; zero_o flags the final cycle of a phase.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/coffee_brew_seq.sv
// Brew sequencer: walks grinder, heater wait, pump and frother phases for one drink.
// Sole owner of the actuator enables; all outputs are decoded from the state register.
module coffee_brew_seq
    import coffee_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int GRIND_CYC    = DEF_GRIND_CYC,
    parameter int HEAT_TIMEOUT = DEF_HEAT_TIMEOUT,
    parameter int POUR_SHORT   = DEF_POUR_SHORT,
    parameter int POUR_LONG    = DEF_POUR_LONG,
    parameter int MILK_CYC     = DEF_MILK_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [1:0] drink_i,
    input  logic       water_hot_i,
    input  logic       abort_i,
    input  logic       clr_fault_i,
    output logic       grinder_en_o,
    output logic       pump_en_o,
    output logic       milk_en_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       fault_o
);

    if (!fitsWidth(GRIND_CYC, CNT_W) || !fitsWidth(HEAT_TIMEOUT, CNT_W) ||
        !fitsWidth(POUR_SHORT, CNT_W) || !fitsWidth(POUR_LONG, CNT_W) ||
        !fitsWidth(MILK_CYC, CNT_W)) begin : gBadPhaseLength
        $error("coffee_brew_seq: a phase length is < 1 or does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] GRIND_LD      = CNT_W'(GRIND_CYC - 1);
    localparam logic [CNT_W-1:0] HEAT_LD       = CNT_W'(HEAT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] POUR_SHORT_LD = CNT_W'(POUR_SHORT - 1);
    localparam logic [CNT_W-1:0] POUR_LONG_LD  = CNT_W'(POUR_LONG - 1);
    localparam logic [CNT_W-1:0] MILK_LD       = CNT_W'(MILK_CYC - 1);

    state_t state_q, state_d;
    drink_t drink_q, drink_d;

    logic             tmrLoad;
    logic [CNT_W-1:0] tmrLoadVal;
    logic             tmrDec;
    logic             tmrZero;

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_phase_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmrLoad),
        .load_val_i(tmrLoadVal),
        .dec_i     (tmrDec),
        .zero_o    (tmrZero)
    );

    // Abort wins over every other transition in the active brewing phases.
    always_comb begin
        state_d    = state_q;
        drink_d    = drink_q;
        tmrLoad    = 1'b0;
        tmrLoadVal = '0;
        tmrDec     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i && (drink_i != DRINK_NONE)) begin
                    drink_d    = drink_t'(drink_i);
                    tmrLoad    = 1'b1;
                    tmrLoadVal = GRIND_LD;
                    state_d    = GRIND;
                end
            end
            GRIND: begin
                if (abort_i) begin
                    drink_d = DRINK_NONE;
                    state_d = IDLE;
                end else if (tmrZero) begin
                    tmrLoad    = 1'b1;
                    tmrLoadVal = HEAT_LD;
                    state_d    = HEAT_WAIT;
                end else begin
                    tmrDec = 1'b1;
                end
            end
            HEAT_WAIT: begin
                if (abort_i) begin
                    drink_d = DRINK_NONE;
                    state_d = IDLE;
                end else if (water_hot_i) begin
                    tmrLoad    = 1'b1;
                    tmrLoadVal = (drink_q == DRINK_LONG) ? POUR_LONG_LD : POUR_SHORT_LD;
                    state_d    = POUR;
                end else if (tmrZero) begin
                    state_d = FAULT;
                end else begin
                    tmrDec = 1'b1;
                end
            end
            POUR: begin
                if (abort_i) begin
                    drink_d = DRINK_NONE;
                    state_d = IDLE;
                end else if (tmrZero) begin
                    if (drink_q == DRINK_CAPP) begin
                        tmrLoad    = 1'b1;
                        tmrLoadVal = MILK_LD;
                        state_d    = MILK;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    tmrDec = 1'b1;
                end
            end
            MILK: begin
                if (abort_i) begin
                    drink_d = DRINK_NONE;
                    state_d = IDLE;
                end else if (tmrZero) begin
                    state_d = DONE;
                end else begin
                    tmrDec = 1'b1;
                end
            end
            DONE: begin
                drink_d = DRINK_NONE;
                state_d = IDLE;
            end
            FAULT: begin
                if (clr_fault_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                drink_d = DRINK_NONE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            drink_q <= DRINK_NONE;
        end else begin
            state_q <= state_d;
            drink_q <= drink_d;
        end
    end

    assign grinder_en_o = (state_q == GRIND);
    assign pump_en_o    = (state_q == POUR);
    assign milk_en_o    = (state_q == MILK);
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign fault_o      = (state_q == FAULT);

endmodule

// File: tb/tb_coffee_brew_seq.sv
// Randomized scoreboard bench for coffee_brew_seq: a phase-arithmetic model predicts each
// brew outcome, and a monitor compares what it observes whenever a brew ends.
module tb_coffee_brew_seq;
    import coffee_pkg::*;

    localparam int G  = 8;
    localparam int HT = 32;
    localparam int PS = 10;
    localparam int PL = 20;
    localparam int MC = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [1:0] drink_i;
    logic       water_hot_i;
    logic       abort_i;
    logic       clr_fault_i;
    logic       grinder_en_o;
    logic       pump_en_o;
    logic       milk_en_o;
    logic       busy_o;
    logic       done_o;
    logic       fault_o;

    coffee_brew_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .drink_i     (drink_i),
        .water_hot_i (water_hot_i),
        .abort_i     (abort_i),
        .clr_fault_i (clr_fault_i),
        .grinder_en_o(grinder_en_o),
        .pump_en_o   (pump_en_o),
        .milk_en_o   (milk_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .fault_o     (fault_o)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_DONE = 2'd0, EV_ABORT = 2'd1, EV_FAULT = 2'd2} ev_t;
    typedef struct packed {
        ev_t kind;
        int  grind;
        int  pump;
        int  milk;
        int  endCyc;
    } txn_t;

    txn_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clip(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Cycles are counted from the edge sampling start: grind occupies 1..G, the heater
    // wait follows, then the pour, the optional milk phase and a single done cycle.
    function automatic txn_t predict(input logic [1:0] d, input int hotCycle, input int abortCyc);
        txn_t t;
        int   e, h, p, m;
        e = (hotCycle > G + 1) ? hotCycle : G + 1;
        t.grind = G; t.pump = 0; t.milk = 0;
        if (e > G + HT) begin
            t.kind   = EV_FAULT;
            t.endCyc = G + HT + 1;
            h = HT; p = 0; m = 0;
        end else begin
            h = e - G;
            p = (d == 2'b10) ? PL : PS;
            m = (d == 2'b11) ? MC : 0;
            t.kind   = EV_DONE;
            t.pump   = p;
            t.milk   = m;
            t.endCyc = G + h + p + m + 1;
        end
        if (abortCyc != 0) begin
            t.kind   = EV_ABORT;
            t.grind  = clip(abortCyc, 0, G);
            t.pump   = clip(abortCyc - G - h, 0, p);
            t.milk   = clip(abortCyc - G - h - p, 0, m);
            t.endCyc = abortCyc;
        end
        return t;
    endfunction

    // Monitor: accumulates enable activity per brew and scores it when the brew ends.
    int cyc = 0, gc = 0, pc = 0, mcnt = 0;
    bit prevBusy = 0, prevFault = 0, doneSeen = 0;

    task automatic scoreEvent(input ev_t kind);
        txn_t e;
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_event: got kind %0d, expected none", kind);
        end else begin
            e = expQ.pop_front();
            checkOutput("event_kind", int'(kind), int'(e.kind));
            checkOutput("grind_cycles", gc, e.grind);
            checkOutput("pump_cycles", pc, e.pump);
            checkOutput("milk_cycles", mcnt, e.milk);
            checkOutput("end_cycle", cyc, e.endCyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cyc = 0; gc = 0; pc = 0; mcnt = 0;
            prevBusy = 0; prevFault = 0; doneSeen = 0;
        end else begin
            if (int'(grinder_en_o) + int'(pump_en_o) + int'(milk_en_o) > 1) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL one_hot_enables: got %b, expected at most one set",
                         {grinder_en_o, pump_en_o, milk_en_o});
            end
            if (busy_o && !prevFault) begin
                cyc++;
                gc   += int'(grinder_en_o);
                pc   += int'(pump_en_o);
                mcnt += int'(milk_en_o);
                if (done_o) doneSeen = 1;
            end
            if (fault_o && !prevFault) begin
                scoreEvent(EV_FAULT);
            end else if (!busy_o && prevBusy && !prevFault) begin
                scoreEvent(doneSeen ? EV_DONE : EV_ABORT);
            end
            if (!busy_o) begin
                cyc = 0; gc = 0; pc = 0; mcnt = 0; doneSeen = 0;
            end
            prevBusy  = busy_o;
            prevFault = fault_o;
        end
    end

    // One brew: push the prediction, then drive start, water_hot, abort and stray starts.
    task automatic applyStimulus(input logic [1:0] d, input int hotCycle, input bit drop,
                                 input int abortCyc, input int busyStartCyc);
        txn_t t;
        int   e;
        t = predict(d, hotCycle, abortCyc);
        e = (hotCycle > G + 1) ? hotCycle : G + 1;
        expQ.push_back(t);
        start_i = 1'b1;
        drink_i = d;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c <= t.endCyc; c++) begin
            water_hot_i = (c >= hotCycle) && (!drop || c <= e);
            abort_i     = (c == abortCyc);
            if (c == busyStartCyc) begin
                start_i = 1'b1;
                drink_i = 2'($urandom_range(1, 3));
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0; abort_i = 1'b0; water_hot_i = 1'b0;
        if (t.kind == EV_FAULT) begin
            repeat (8) begin
                @(posedge clk); #1;
            end
            checkOutput("fault_held", int'(fault_o), 1);
            checkOutput("busy_in_fault", int'(busy_o), 1);
            clr_fault_i = 1'b1;
            @(posedge clk); #1;
            clr_fault_i = 1'b0;
            checkOutput("fault_cleared", int'(fault_o), 0);
            checkOutput("idle_after_clear", int'(busy_o), 0);
        end
        @(posedge clk); #1;
    endtask

    // Cappuccino interrupted by an asynchronous reset in the middle of the milk phase.
    task automatic resetMidMilk();
        start_i = 1'b1;
        drink_i = 2'b11;
        water_hot_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c < 30; c++) begin
            @(posedge clk); #1;
        end
        checkOutput("milk_before_reset", int'(milk_en_o), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("outputs_in_async_reset",
                    int'({grinder_en_o, pump_en_o, milk_en_o, busy_o, done_o, fault_o}), 0);
        #4 rst = 1'b0;
        water_hot_i = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_after_reset", int'(busy_o), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        txn_t t0, t1;
        int   hot, a, bs, last;
        logic [1:0] d;

        rst = 1'b1; start_i = 1'b0; drink_i = 2'b00;
        water_hot_i = 1'b0; abort_i = 1'b0; clr_fault_i = 1'b0;
        #12;
        checkOutput("outputs_during_reset",
                    int'({grinder_en_o, pump_en_o, milk_en_o, busy_o, done_o, fault_o}), 0);
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("outputs_after_reset",
                    int'({grinder_en_o, pump_en_o, milk_en_o, busy_o, done_o, fault_o}), 0);

        $display("[TB] directed: espresso, water already hot");
        applyStimulus(2'b01, 0, 0, 0, 0);
        $display("[TB] directed: cappuccino, water hot from cycle 14");
        applyStimulus(2'b11, 14, 0, 0, 0);
        $display("[TB] directed: long espresso, heater never ready");
        applyStimulus(2'b10, 1000, 0, 0, 0);
        applyStimulus(2'b01, 0, 0, 0, 0);
        $display("[TB] directed: abort during espresso pour");
        applyStimulus(2'b01, 0, 0, 12, 0);

        start_i = 1'b1; drink_i = 2'b00;
        @(posedge clk); #1;
        start_i = 1'b0;
        checkOutput("start_drink00_ignored", int'(busy_o), 0);

        $display("[TB] directed: long-espresso start during espresso grind");
        expQ.push_back(predict(2'b01, 0, 0));
        start_i = 1'b1; drink_i = 2'b01; water_hot_i = 1'b1;
        @(posedge clk); #1;
        drink_i = 2'b10;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        water_hot_i = 1'b0;

        $display("[TB] directed: reset in milk phase, then espresso");
        resetMidMilk();
        applyStimulus(2'b01, 0, 0, 0, 0);

        $display("[TB] randomized brews");
        for (int n = 0; n < 40; n++) begin
            d   = 2'($urandom_range(1, 3));
            hot = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, G + 14));
            t0  = predict(d, hot, 0);
            a   = 0;
            if ($urandom_range(0, 3) == 0) begin
                last = (t0.kind == EV_FAULT) ? G + HT : t0.endCyc - 1;
                a = int'($urandom_range(1, last));
            end
            t1 = predict(d, hot, a);
            bs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, t1.endCyc)) : 0;
            applyStimulus(d, hot, 1'($urandom_range(0, 1)), a, bs);
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/coffee_brew_seq.md
Name: coffee_brew_seq

Overview:
Sequencer for the shared brewing hardware: grinder, water pump and milk frother. It sits behind the credit/selection FSM, which issues a one-cycle start pulse together with the drink code. The block then drives the actuator enables through timed phases and returns busy, done and fault status. It is the only block allowed to assert the actuator enables.

Parameters:
CNT_W, 8, width of the phase/timeout counter
GRIND_CYC, 8, grinder-on duration in cycles (>=1)
HEAT_TIMEOUT, 32, maximum cycles to wait for water_hot before fault (>=1)
POUR_SHORT, 10, pump-on cycles for espresso and cappuccino base (>=1)
POUR_LONG, 20, pump-on cycles for long espresso (>=1)
MILK_CYC, 12, frother-on cycles for cappuccino (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request pulse from the selection FSM
drink  in  2  01 espresso, 10 long espresso, 11 cappuccino; 00 is invalid
water_hot  in  1  heater at temperature (level signal)
abort  in  1  cancel the current brew (level, sampled each cycle)
clr_fault  in  1  one-cycle pulse; leaves FAULT
grinder_en  out  1  grinder drive
pump_en  out  1  pump drive
milk_en  out  1  frother drive
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on successful completion
fault  out  1  high while in FAULT

Behaviour:
- Reset state is IDLE. drink_q=00 and counter=0. All outputs are 0 during and after reset. Reset mid-brew drops all enables immediately, because reset is asynchronous.
- Moore machine: all outputs decode only from the registered state.
- States and transitions:
  - IDLE: if start=1 and drink!=00, latch drink into drink_q, load counter=GRIND_CYC-1, go to GRIND. Otherwise stay. start with drink=00 is ignored.
  - GRIND: grinder_en=1. Decrement the counter. When counter==0, load HEAT_TIMEOUT-1 and go to HEAT_WAIT. Total GRIND_CYC cycles.
  - HEAT_WAIT: all enables 0.
    - If water_hot=1, load the pour length and go to POUR. Pour length is POUR_LONG-1 for drink_q=10 and POUR_SHORT-1 otherwise.
    - Else if counter==0, go to FAULT.
    - Else decrement.
    - Minimum dwell is 1 cycle even if water_hot is already high. Maximum dwell is HEAT_TIMEOUT cycles.
  - POUR: pump_en=1 for exactly the loaded length. At counter==0: if drink_q=11, load MILK_CYC-1 and go to MILK; otherwise go to DONE.
  - MILK: milk_en=1 for MILK_CYC cycles, then go to DONE.
  - DONE: done=1 for one cycle. Clear drink_q. Go to IDLE.
  - FAULT: fault=1, enables 0, busy=1. Stays until clr_fault=1, then goes to IDLE. Sticky.
- water_hot is only examined in HEAT_WAIT. A drop of water_hot during POUR is ignored.
- abort=1 in GRIND, HEAT_WAIT, POUR or MILK sends the machine to IDLE on the next edge: no done pulse, drink_q cleared. abort has priority over every other transition in the same cycle. abort is ignored in IDLE, DONE and FAULT.
- start while busy=1 is ignored and is not queued.
- At most one enable is high in any cycle. The bench asserts this continuously.
- Counter width rule: every phase length minus 1 must fit in CNT_W bits. This is checked by an elaboration-time check.
- Latency with defaults, counting from the edge that samples start:
  - espresso: done is high at cycle 1+8+h+10, where h is HEAT_WAIT dwell (>=1)
  - long espresso: done at 1+8+h+20
  - cappuccino: done at 1+8+h+10+12

Decomposition:
- Package coffee_pkg:
  - drink codes DRINK_NONE/ESPR/LONG/CAPP
  - 3-bit state encodings IDLE, GRIND, HEAT_WAIT, POUR, MILK, DONE, FAULT
  - default phase lengths
- One sub-module, phase_timer: CNT_W-bit loadable down-counter with inputs load, load_val and dec, and output zero flag.
- The FSM and output decode stay in coffee_brew_seq.

Test Plan:
1. Espresso, water_hot=1 constant, start+drink=01 sampled at edge 0 -> grinder_en cycles 1-8, HEAT_WAIT cycle 9, pump_en cycles 10-19, done=1 at cycle 20 only, busy low from 21.
2. Cappuccino, water_hot rises at cycle 14 -> HEAT_WAIT cycles 9-14, pump_en 15-24, milk_en 25-36, done at 37; milk never overlaps pump.
3. Long espresso with water_hot=0 always -> HEAT_WAIT cycles 9-40, fault=1 from 41, enables 0. clr_fault at 50 -> IDLE at 51. A following espresso completes normally.
4. abort=1 at cycle 12 during POUR of espresso -> pump_en=0 and busy=0 from cycle 13, no done pulse, drink_q=00.
5. start with drink=00 in IDLE -> no state change. start with drink=10 during GRIND of an espresso -> ignored; pour length stays 10 cycles.
6. rst asserted mid-MILK (asynchronously, between edges) -> all outputs 0 immediately. After rst release, the next start behaves as in scenario 1.
